// File: rtl/mux_pkg.sv
// Shared definitions for the stream_mux_n family: output register state
// encoding, channel count limit and the select-width helper.
package mux_pkg;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } mux_state_e;

  localparam int MUX_MAX_N = 16;

  // Width of a channel index for n channels, never narrower than one bit.
  function automatic int sel_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requesting channel at or
// after ptr, wrapping modulo N.
module rr_arbiter #(
  parameter int N    = 4,
  parameter int SELW = 2
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic [SELW-1:0] grant,
  output logic            any_grant
);

  int   idx_v;
  logic hit_s;

  // Walk the search order backwards so the highest-priority hit is written last.
  always_comb begin
    grant     = {SELW{1'b0}};
    any_grant = 1'b0;
    idx_v     = 0;
    hit_s     = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      idx_v     = (int'(ptr) + k >= N) ? (int'(ptr) + k - N) : (int'(ptr) + k);
      hit_s     = req[idx_v];
      grant     = hit_s ? SELW'(idx_v) : grant;
      any_grant = any_grant | hit_s;
    end
  end

endmodule

// File: rtl/stream_mux_n.sv
// Registered N:1 valid/ready stream multiplexer with manual select and,
// when MUX_RR_EN is defined, round-robin arbitration selected by rr_mode.
module stream_mux_n
  import mux_pkg::*;
#(
  parameter int N    = 4,
  parameter int W    = 8,
  parameter int SELW = sel_width(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    in_valid,
  input  logic [N*W-1:0]  in_data,
  output logic [N-1:0]    in_ready,
  input  logic [SELW-1:0] sel,
  input  logic            rr_mode,
  output logic            out_valid,
  output logic [W-1:0]    out_data,
  output logic [SELW-1:0] out_chan,
  input  logic            out_ready
);

  mux_state_e      state_r;
  logic [W-1:0]    data_r;
  logic [SELW-1:0] chan_r;

  logic [SELW-1:0] man_grant_s;
  logic            man_any_s;
  logic [SELW-1:0] grant_s;
  logic            grant_any_s;
  logic            load_en_s;
  logic            xfer_s;
  logic [W-1:0]    data_sel_s;
  logic [N-1:0]    in_ready_s;

  // Manual grant: sel must name an existing channel that is presenting data.
  always_comb begin
    man_grant_s = sel;
    man_any_s   = 1'b0;
    for (int i = 0; i < N; i++) begin
      man_any_s = man_any_s | ((int'(sel) == i) & in_valid[i]);
    end
  end

`ifdef MUX_RR_EN
  logic [SELW-1:0] ptr_r;
  logic [SELW-1:0] rr_grant_s;
  logic            rr_any_s;

  rr_arbiter #(
    .N    (N),
    .SELW (SELW)
  ) u_rr_arbiter (
    .req       (in_valid),
    .ptr       (ptr_r),
    .grant     (rr_grant_s),
    .any_grant (rr_any_s)
  );

  // Mode switch acts on the current cycle's grant.
  always_comb begin
    if (rr_mode) begin
      grant_s     = rr_grant_s;
      grant_any_s = rr_any_s;
    end else begin
      grant_s     = man_grant_s;
      grant_any_s = man_any_s;
    end
  end

  // Pointer advances past the winner only on round-robin transfers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_r <= {SELW{1'b0}};
    end else if (xfer_s && rr_mode) begin
      ptr_r <= (int'(grant_s) == N - 1) ? {SELW{1'b0}} : grant_s + SELW'(1);
    end else begin
      ptr_r <= ptr_r;
    end
  end
`else
  logic unused_rr_mode_s;
  assign unused_rr_mode_s = rr_mode;

  // Without the arbiter the manual grant is the only grant.
  always_comb begin
    grant_s     = man_grant_s;
    grant_any_s = man_any_s;
  end
`endif

  assign load_en_s = (state_r == ST_EMPTY) | (out_ready & out_valid);
  assign xfer_s    = grant_any_s & load_en_s;

  // One-hot ready towards the granted channel and data steering from it.
  always_comb begin
    data_sel_s = {W{1'b0}};
    in_ready_s = {N{1'b0}};
    for (int i = 0; i < N; i++) begin
      in_ready_s[i] = xfer_s & (grant_s == SELW'(i));
      data_sel_s    = data_sel_s | ({W{grant_s == SELW'(i)}} & in_data[i*W +: W]);
    end
  end

  assign in_ready = in_ready_s & {N{~rst}};

  // Output register FSM: loads on transfer, drains on out_ready, else holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_EMPTY;
      data_r  <= {W{1'b0}};
      chan_r  <= {SELW{1'b0}};
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (xfer_s) begin
            state_r <= ST_FULL;
            data_r  <= data_sel_s;
            chan_r  <= grant_s;
          end else begin
            state_r <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (xfer_s) begin
            state_r <= ST_FULL;
            data_r  <= data_sel_s;
            chan_r  <= grant_s;
          end else if (out_ready) begin
            state_r <= ST_EMPTY;
          end else begin
            state_r <= ST_FULL;
          end
        end
        default: begin
          state_r <= ST_EMPTY;
        end
      endcase
    end
  end

  assign out_valid = (state_r == ST_FULL);
  assign out_data  = data_r;
  assign out_chan  = chan_r;

endmodule

// File: doc/stream_mux_n.md
# stream_mux_n

Parametrised N-input, registered stream multiplexer with valid/ready handshakes on every input and on the output. It is the successor to the combinational 4:1 data-flow multiplexer and sits between several producer streams and one consumer. It selects a channel either by an explicit select input or, when compiled in, by round-robin arbitration. The selected word and its channel index are registered, and the block sustains one transfer per cycle under back-pressure.

## Interface
Parameters:
- N, 4, number of input channels (2..16)
- W, 8, data width per channel
- SELW, $clog2(N), select/channel index width (derived; do not override)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  N  per-channel valid
- in_data  input  N*W  channel i occupies bits [i*W +: W]
- in_ready  output  N  per-channel ready (one-hot or zero)
- sel  input  SELW  manual channel select
- rr_mode  input  1  1 = round-robin, 0 = manual (ignored without MUX_RR_EN)
- out_valid  output  1  output word valid
- out_data  output  W  registered selected word
- out_chan  output  SELW  index of channel that supplied out_data
- out_ready  input  1  consumer ready

One clock; reset is asynchronous and active-high.

## Operation
- Output register states:
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
- load_en = EMPTY | (out_ready & out_valid).
- Grant g is combinational:
  - Manual: g = sel if sel < N and in_valid[sel]; otherwise no grant.
  - Round-robin: g = first i with in_valid[i], searching from ptr upward with wrap modulo N; no grant if all in_valid = 0.
- in_ready[g] = load_en; every other in_ready bit is 0. in_ready is never asserted without a grant.
- Transfer on channel g occurs when in_valid[g] & in_ready[g]. On transfer, at the next edge:
  - out_data <= in_data[g]
  - out_chan <= g
  - state <= FULL
- FULL & out_ready with no new transfer -> EMPTY.
- FULL & out_ready with a new transfer -> stays FULL with the new word (back-to-back).
- FULL & !out_ready -> out_data and out_chan held stable. A change of sel or rr_mode has no effect on the held word.
- Round-robin pointer: on transfer, ptr <= (g == N-1) ? 0 : g+1. ptr is unchanged when there is no transfer and in manual mode.
- Out-of-range sel (sel >= N): no grant and no transfer; existing output is still drained normally.

## Timing
- Reset values:
  - out_valid=0, out_data=0, out_chan=0, ptr=0, state EMPTY.
  - in_ready=0 while rst is high.
- Latency: input transfer at edge k -> out_valid high after edge k, visible in cycle k+1.
- Throughput: 1 word/cycle while out_ready stays high.
- in_ready depends combinationally on in_valid, sel, rr_mode, state and out_ready. out_* depend on registers only.
- Reset asserted mid-operation discards the held word immediately (asynchronously). It never produces a partial output.
- Switching rr_mode takes effect on the same cycle's grant; ptr is retained across mode switches.

## Configuration
- MUX_RR_EN defined: round-robin arbiter and ptr register are built, and rr_mode is honoured.
- MUX_RR_EN undefined:
  - Manual select only; rr_mode is ignored.
  - No ptr register or arbiter logic is built.
  - Behaviour is identical to defined-with-rr_mode=0.

## Structure
- Shared package mux_pkg:
  - state encoding (ST_EMPTY=1'b0, ST_FULL=1'b1)
  - MUX_MAX_N=16 limit constant
  - function computing SELW
- One sub-module: rr_arbiter.
  - Parameter N.
  - Inputs req[N], ptr.
  - Outputs grant index and any_grant.
  - Instantiated only under MUX_RR_EN.
- Top handles the output register, the handshake and the ptr update.

## Test plan
- Reset: assert rst mid-stream with out_valid=1 -> out_valid=0, out_data=0, out_chan=0 immediately; in_ready=0.
- Manual select, N=4, W=8:
  - Stimulus: sel=2, in_data ch2=8'hA5, all valid, out_ready=1.
  - Response: in_ready=4'b0100; next cycle out_data=8'hA5, out_chan=2.
- Back-pressure: out_ready=0 for 3 cycles while FULL with 8'h3C -> in_ready=0, out_data stays 8'h3C. Release -> next word loads on the same edge the old word drains.
- Round-robin (MUX_RR_EN), all four channels valid continuously, out_ready=1 -> out_chan sequence 0,1,2,3,0; ptr wraps from 3 to 0.
- Round-robin sparse: only ch1 and ch3 valid, ptr=2 -> ch3 granted first, then ch1.
- Out-of-range: N=3, sel=3 -> in_ready=0; out_valid falls after the held word drains.
